ftdi_tx_arbiter: RTL and testbench
==================================

# ftdi_tx_arbiter

Shares the single FTDI transmit path between two channel FIFOs, each gated by its own kilobyte-ready controller. Grants one channel at a time for a complete burst of BURST_LEN bytes, optionally prefixed by a one-byte channel header. Arbitration is round-robin. The block drives the selected FIFO's read request and the FTDI write strobe. It sits between the per-channel FIFO controllers and the FTDI write interface.

## Interface
Parameters:
- BURST_LEN, 1024: bytes per granted burst, excluding the header.
- CNT_W, 11: byte counter width; must satisfy 2^CNT_W > BURST_LEN.
- HEADER_EN, 1: 1 = send a header byte before each burst.
- HEADER_BASE, 8'hA0: header value is HEADER_BASE | channel index.
- GAP_CYCLES, 2: idle cycles after each burst before re-arbitration; minimum 1.

Ports:
- clk, in, 1: single clock; everything is on the rising edge.
- rst, in, 1: asynchronous, active-high reset.
- ch0_tx_rdy, ch1_tx_rdy, in, 1 each: the channel has at least BURST_LEN bytes ready.
- ch0_fifo_q, ch1_fifo_q, in, 8 each: show-ahead FIFO output data.
- ch0_rdreq, ch1_rdreq, out, 1 each: FIFO read acknowledge.
- ftdi_rx_rdy, in, 1: FTDI accepts a byte this cycle.
- ftdi_data, out, 8: byte to FTDI.
- ftdi_wrreq, out, 1: a byte transfers this cycle.
- grant, out, 2: one-hot grant to the active channel; 2'b00 when none.
- busy, out, 1: high in any state other than IDLE.
- burst_done, out, 1: one-cycle pulse after the last byte of a burst.

## Operation
States: IDLE, HEADER, BURST, GAP.
- **IDLE**
  - If neither tx_rdy is high, stay in IDLE.
  - If exactly one tx_rdy is high, select that channel.
  - If both are high, select the channel not equal to last_grant.
  - On a selection: set grant, update last_grant, and go to HEADER if HEADER_EN=1, else BURST.
- **HEADER**
  - ftdi_data = HEADER_BASE | ch.
  - ftdi_wrreq = ftdi_rx_rdy.
  - No rdreq is driven.
  - When ftdi_rx_rdy is high, go to BURST.
- **BURST**
  - ftdi_data = selected fifo_q.
  - ftdi_wrreq = ftdi_rx_rdy.
  - The granted channel's rdreq = ftdi_rx_rdy; the other channel's rdreq = 0.
  - cnt increments on each transfer.
  - A transfer with cnt == BURST_LEN-1 goes to GAP, clears cnt, and sets burst_done for the next cycle.
- **GAP**
  - Counts GAP_CYCLES cycles, then goes to IDLE and drops grant.
  - Lets the channel controller deassert its tx_rdy.
- Data-path outputs:
  - ftdi_wrreq, rdreq and ftdi_data are combinational from the state and ftdi_rx_rdy.
  - ftdi_data = 0 in IDLE and GAP.
- tx_rdy inputs are sampled only in IDLE. A tx_rdy drop mid-burst is ignored, because a ready channel guarantees BURST_LEN words.
- ftdi_rx_rdy low stalls HEADER and BURST indefinitely; cnt holds.

## Timing
- Reset (async) forces:
  - state = IDLE, cnt = 0, gap counter = 0.
  - last_grant = 1, so ch0 wins the first tie.
  - Outputs all 0: grant, busy, burst_done, ftdi_wrreq, ch0_rdreq, ch1_rdreq, ftdi_data.
- Reset mid-burst:
  - The burst is abandoned.
  - No rdreq or wrreq appears in the cycle after release.
- Start-up latency:
  - tx_rdy seen high in IDLE at edge N: grant and busy are high from edge N+1.
  - The first transfer (header or data) can occur in the cycle after edge N+1.
- Burst length on the FTDI side: exactly HEADER_EN + BURST_LEN wrreq cycles per grant.
- Exactly BURST_LEN rdreq cycles to the granted FIFO per grant.
- Minimum spacing between bursts: GAP_CYCLES + 1 cycles with no wrreq.
- burst_done is high for exactly 1 cycle: the first GAP cycle.
- cnt never reaches BURST_LEN.

## Structure
- Shared package `ftdi_tx_pkg`:
  - State enum (IDLE/HEADER/BURST/GAP).
  - HEADER_BASE and BURST_LEN defaults.
  - Channel index type.
- Sub-module `ftdi_rr_pick`:
  - Combinational 2-way round-robin picker.
  - Inputs: req[1:0], last_grant. Outputs: grant one-hot, valid.
- The state machine, counters and muxes stay in the top module.

## Test plan
- **Single channel:** ch0_tx_rdy=1, ftdi_rx_rdy=1 constant, FIFO q = incrementing bytes 0..255 → 0xA0, then 1024 data bytes; ch0_rdreq count = 1024; burst_done pulses once; ch1_rdreq is never high.
- **Tie and alternation:** both tx_rdy high continuously → grants go ch0, ch1, ch0, ch1; headers are 0xA0, 0xA1, 0xA0, 0xA1; ≥3 idle wrreq cycles between bursts.
- **Backpressure:** ftdi_rx_rdy toggles at random at 50% → still exactly 1025 wrreq and 1024 rdreq per burst; ftdi_data matches the FIFO sequence with no duplicates or drops.
- **Mid-burst tx_rdy drop:** drop ch0_tx_rdy after 300 bytes → the burst still completes its 1024 bytes; no switch to ch1 until after GAP.
- **Reset mid-burst:** assert rst after 500 bytes → all outputs are 0 in the same cycle; after release with ch1_tx_rdy=1 only, the next header is 0xA1.
- **HEADER_EN=0 and BURST_LEN=16 build:** ch1 ready → exactly 16 wrreq cycles, first ftdi_data = ch1 q; burst_done on the cycle after the 16th transfer.

Source files
------------

// File: rtl/ftdi_tx_pkg.sv
// Shared types and defaults for the two-channel FTDI transmit arbiter.
package ftdi_tx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    BURST  = 2'd2,
    GAP    = 2'd3
  } state_t;

  localparam logic [7:0]  HEADER_BASE_DEF = 8'hA0;
  localparam int unsigned BURST_LEN_DEF   = 1024;

  typedef logic ch_idx_t;

  function automatic logic [1:0] ch_onehot(input ch_idx_t ch);
    return ch ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ftdi_tx_arbiter_pick.sv
// Combinational two-way round-robin picker: a tie goes to the channel not granted last.
module ftdi_rr_pick
  import ftdi_tx_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic [1:0] o_grant,
  output logic       o_valid
);

  always_comb begin
    o_grant = 2'b00;
    unique case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = ch_onehot(~i_last_grant);
      default: o_grant = 2'b00;
    endcase
    o_valid = |i_req;
  end

endmodule

// File: rtl/ftdi_tx_arbiter.sv
// Shares the FTDI transmit path between two channel FIFOs, one full burst per grant,
// optionally prefixed by a channel header byte, with round-robin arbitration.
module ftdi_tx_arbiter
  import ftdi_tx_pkg::*;
#(
  parameter int unsigned BURST_LEN   = BURST_LEN_DEF,
  parameter int unsigned CNT_W       = 11,
  parameter int unsigned HEADER_EN   = 1,
  parameter logic [7:0]  HEADER_BASE = HEADER_BASE_DEF,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ch0_tx_rdy,
  input  logic       i_ch1_tx_rdy,
  input  logic [7:0] i_ch0_fifo_q,
  input  logic [7:0] i_ch1_fifo_q,
  output logic       o_ch0_rdreq,
  output logic       o_ch1_rdreq,
  input  logic       i_ftdi_rx_rdy,
  output logic [7:0] o_ftdi_data,
  output logic       o_ftdi_wrreq,
  output logic [1:0] o_grant,
  output logic       o_busy,
  output logic       o_burst_done
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [GAP_W-1:0] r_gap_cnt, w_gap_nxt;
  logic             r_last_grant, w_last_nxt;
  ch_idx_t          r_ch, w_ch_nxt;
  logic [1:0]       r_grant, w_grant_nxt;
  logic             r_burst_done, w_done_nxt;

  logic [1:0]       w_pick_grant;
  logic             w_pick_valid;

  ftdi_rr_pick u_pick (
    .i_req        ({i_ch1_tx_rdy, i_ch0_tx_rdy}),
    .i_last_grant (r_last_grant),
    .o_grant      (w_pick_grant),
    .o_valid      (w_pick_valid)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_gap_cnt    <= '0;
      r_last_grant <= 1'b1;
      r_ch         <= 1'b0;
      r_grant      <= 2'b00;
      r_burst_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_gap_cnt    <= w_gap_nxt;
      r_last_grant <= w_last_nxt;
      r_ch         <= w_ch_nxt;
      r_grant      <= w_grant_nxt;
      r_burst_done <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_gap_nxt    = r_gap_cnt;
    w_last_nxt   = r_last_grant;
    w_ch_nxt     = r_ch;
    w_grant_nxt  = r_grant;
    w_done_nxt   = 1'b0;
    o_ftdi_data  = 8'h00;
    o_ftdi_wrreq = 1'b0;
    o_ch0_rdreq  = 1'b0;
    o_ch1_rdreq  = 1'b0;
    unique case (r_state)
      IDLE: begin
        // tx_rdy is only looked at here; a ready channel guarantees a full burst.
        if (w_pick_valid) begin
          w_grant_nxt = w_pick_grant;
          w_ch_nxt    = w_pick_grant[1];
          w_last_nxt  = w_pick_grant[1];
          w_state_nxt = (HEADER_EN != 0) ? HEADER : BURST;
        end
      end
      HEADER: begin
        o_ftdi_data  = HEADER_BASE | {7'd0, r_ch};
        o_ftdi_wrreq = i_ftdi_rx_rdy;
        if (i_ftdi_rx_rdy) w_state_nxt = BURST;
      end
      BURST: begin
        o_ftdi_data  = r_ch ? i_ch1_fifo_q : i_ch0_fifo_q;
        o_ftdi_wrreq = i_ftdi_rx_rdy;
        o_ch0_rdreq  = i_ftdi_rx_rdy & ~r_ch;
        o_ch1_rdreq  = i_ftdi_rx_rdy & r_ch;
        if (i_ftdi_rx_rdy) begin
          if (r_cnt == CNT_LAST) begin
            w_cnt_nxt   = '0;
            w_done_nxt  = 1'b1;
            w_state_nxt = GAP;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_gap_nxt   = '0;
          w_grant_nxt = 2'b00;
          w_state_nxt = IDLE;
        end else begin
          w_gap_nxt = r_gap_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_grant      = r_grant;
  assign o_busy       = (r_state != IDLE);
  assign o_burst_done = r_burst_done;

endmodule

// File: tb/tb_ftdi_tx_arbiter.sv
// Self-checking bench: random backpressure against a queue-based model of bursts,
// headers and round-robin order; a second small build checks HEADER_EN=0.
module tb_ftdi_tx_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main build
  logic       ch0_rdy = 1'b0, ch1_rdy = 1'b0, rx_rdy = 1'b1;
  logic [7:0] ptr0 = 8'd0, ptr1 = 8'd0;
  logic [7:0] q0, q1, data;
  logic       rd0, rdq1, wrreq, busy, done;
  logic [1:0] grant;
  assign q0 = ptr0;
  assign q1 = ptr1 + 8'h80;

  ftdi_tx_arbiter u_dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_ch0_tx_rdy  (ch0_rdy),
    .i_ch1_tx_rdy  (ch1_rdy),
    .i_ch0_fifo_q  (q0),
    .i_ch1_fifo_q  (q1),
    .o_ch0_rdreq   (rd0),
    .o_ch1_rdreq   (rdq1),
    .i_ftdi_rx_rdy (rx_rdy),
    .o_ftdi_data   (data),
    .o_ftdi_wrreq  (wrreq),
    .o_grant       (grant),
    .o_busy        (busy),
    .o_burst_done  (done)
  );

  // Small build: no header, 16-byte bursts
  logic       s_ch0_rdy = 1'b0, s_ch1_rdy = 1'b0;
  logic [7:0] s_ptr0 = 8'd0, s_ptr1 = 8'd0;
  logic [7:0] s_q0, s_q1, s_data;
  logic       s_rd0, s_rd1, s_wrreq, s_busy, s_done;
  logic [1:0] s_grant;
  assign s_q0 = s_ptr0;
  assign s_q1 = s_ptr1 + 8'h80;

  ftdi_tx_arbiter #(.BURST_LEN(16), .CNT_W(5), .HEADER_EN(0)) u_small (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_ch0_tx_rdy  (s_ch0_rdy),
    .i_ch1_tx_rdy  (s_ch1_rdy),
    .i_ch0_fifo_q  (s_q0),
    .i_ch1_fifo_q  (s_q1),
    .o_ch0_rdreq   (s_rd0),
    .o_ch1_rdreq   (s_rd1),
    .i_ftdi_rx_rdy (1'b1),
    .o_ftdi_data   (s_data),
    .o_ftdi_wrreq  (s_wrreq),
    .o_grant       (s_grant),
    .o_busy        (s_busy),
    .o_burst_done  (s_done)
  );

  // Show-ahead FIFO models: a read acknowledge advances to the next byte.
  always @(posedge clk) begin
    if (rd0)   ptr0   <= ptr0 + 8'd1;
    if (rdq1)  ptr1   <= ptr1 + 8'd1;
    if (s_rd0) s_ptr0 <= s_ptr0 + 8'd1;
    if (s_rd1) s_ptr1 <= s_ptr1 + 8'd1;
  end

  // Monitor, sampled on the falling edge
  int         cyc = 0;
  int         n_rd0 = 0, n_rd1 = 0, n_done = 0, s_n_rd0 = 0, s_n_rd1 = 0, s_n_done = 0;
  logic [7:0] wr_data_q[$];
  int         wr_cyc_q[$];
  logic [1:0] wr_gnt_q[$];
  int         done_cyc_q[$];
  logic [7:0] s_wr_data_q[$];
  int         s_wr_cyc_q[$];
  logic [1:0] s_wr_gnt_q[$];
  int         s_done_cyc_q[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (wrreq) begin
      wr_data_q.push_back(data);
      wr_cyc_q.push_back(cyc + 1);
      wr_gnt_q.push_back(grant);
    end
    if (rd0)  n_rd0 <= n_rd0 + 1;
    if (rdq1) n_rd1 <= n_rd1 + 1;
    if (done) begin
      n_done <= n_done + 1;
      done_cyc_q.push_back(cyc + 1);
    end
    if (s_wrreq) begin
      s_wr_data_q.push_back(s_data);
      s_wr_cyc_q.push_back(cyc + 1);
      s_wr_gnt_q.push_back(s_grant);
    end
    if (s_rd0) s_n_rd0 <= s_n_rd0 + 1;
    if (s_rd1) s_n_rd1 <= s_n_rd1 + 1;
    if (s_done) begin
      s_n_done <= s_n_done + 1;
      s_done_cyc_q.push_back(cyc + 1);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int m_last   = 1;
  int b_rd0, b_rd1, b_done, b_srd0, b_srd1, b_sdone;

  // Reference: round-robin choice and FIFO content by plain rules
  function automatic int rr_model(input bit r0, input bit r1, input int last);
    if (r0 && r1) return 1 - last;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  function automatic logic [7:0] fifo_byte(input int ch, input logic [7:0] st, input int i);
    logic [7:0] r;
    r = st + 8'(i);
    if (ch == 1) r = r + 8'h80;
    return r;
  endfunction

  function automatic int seq_errors(input int base, input int ch, input logic [7:0] st,
                                    input int len);
    int bad = 0;
    for (int i = 0; i < len; i++) begin
      if (base + i >= wr_data_q.size()) bad++;
      else if (wr_data_q[base + i] !== fifo_byte(ch, st, i)) bad++;
    end
    return bad;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mark();
    wr_data_q.delete();
    wr_cyc_q.delete();
    wr_gnt_q.delete();
    done_cyc_q.delete();
    s_wr_data_q.delete();
    s_wr_cyc_q.delete();
    s_wr_gnt_q.delete();
    s_done_cyc_q.delete();
    b_rd0 = n_rd0; b_rd1 = n_rd1; b_done = n_done;
    b_srd0 = s_n_rd0; b_srd1 = s_n_rd1; b_sdone = s_n_done;
  endtask

  task automatic wait_done(input int n, input int budget, input bit bp, input int drop0_at,
                           input string name);
    int i = 0;
    while ((n_done - b_done) < n && i < budget) begin
      tick();
      i++;
      if (bp) rx_rdy = 1'($urandom_range(0, 1));
      if (drop0_at > 0 && wr_data_q.size() >= drop0_at) ch0_rdy = 1'b0;
    end
    rx_rdy = 1'b1;
    n_checks++;
    if ((n_done - b_done) < n) begin
      n_fail++;
      $display("FAIL %s_timeout: bursts done %0d, required %0d", name, n_done - b_done, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    n_checks += 8;
    if (grant !== 2'b00) begin n_fail++; $display("FAIL rst_grant: got %b want 00", grant); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
    if (wrreq !== 1'b0) begin n_fail++; $display("FAIL rst_wrreq: got %b want 0", wrreq); end
    if (rd0 !== 1'b0) begin n_fail++; $display("FAIL rst_rd0: got %b want 0", rd0); end
    if (rdq1 !== 1'b0) begin n_fail++; $display("FAIL rst_rd1: got %b want 0", rdq1); end
    if (data !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h want 00", data); end
    if (s_busy !== 1'b0) begin n_fail++; $display("FAIL rst_s_busy: got %b want 0", s_busy); end
    rst = 1'b0;
    m_last = 1;
    repeat (2) tick();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_channel();
    logic [7:0] st;
    int c0, ch, badg, last;
    st = ptr0;
    mark();
    c0 = cyc;
    ch0_rdy = 1'b1;
    ch = rr_model(1, 0, m_last);
    m_last = ch;
    wait_done(1, 3000, 0, 0, "single");
    ch0_rdy = 1'b0;
    repeat (5) tick();
    n_checks += 8;
    if (wr_data_q.size() != 1025) begin
      n_fail++; $display("FAIL single_wr_count: got %0d want 1025", wr_data_q.size());
    end
    if (wr_data_q.size() > 0 && (wr_data_q[0] !== 8'hA0 || wr_cyc_q[0] != c0 + 2)) begin
      n_fail++;
      $display("FAIL single_header: got %h at cyc %0d want a0 at %0d", wr_data_q[0],
               wr_cyc_q[0], c0 + 2);
    end
    if (seq_errors(1, ch, st, 1024) != 0) begin
      n_fail++; $display("FAIL single_data: %0d bad bytes, want 0", seq_errors(1, ch, st, 1024));
    end
    if (n_rd0 - b_rd0 != 1024) begin
      n_fail++; $display("FAIL single_rd0: got %0d want 1024", n_rd0 - b_rd0);
    end
    if (n_rd1 - b_rd1 != 0) begin
      n_fail++; $display("FAIL single_rd1: got %0d want 0", n_rd1 - b_rd1);
    end
    if (n_done - b_done != 1) begin
      n_fail++; $display("FAIL single_done_cnt: got %0d want 1", n_done - b_done);
    end
    last = (wr_cyc_q.size() > 0) ? wr_cyc_q[wr_cyc_q.size() - 1] : -10;
    if (done_cyc_q.size() == 0 || done_cyc_q[0] != last + 1) begin
      n_fail++;
      $display("FAIL single_done_time: got %0d want %0d",
               (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1, last + 1);
    end
    badg = 0;
    foreach (wr_gnt_q[i]) if (wr_gnt_q[i] !== 2'b01) badg++;
    if (badg != 0) begin n_fail++; $display("FAIL single_grant: %0d cycles not 01", badg); end
  endtask

  task automatic test_alternation();
    logic [7:0] st[2];
    int ch, base, gap;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_last = 1;
    st[0] = ptr0;
    st[1] = ptr1;
    mark();
    ch0_rdy = 1'b1;
    ch1_rdy = 1'b1;
    wait_done(4, 6000, 0, 0, "alt");
    ch0_rdy = 1'b0;
    ch1_rdy = 1'b0;
    repeat (5) tick();
    n_checks += 3;
    if (wr_data_q.size() != 4100) begin
      n_fail++; $display("FAIL alt_wr_count: got %0d want 4100", wr_data_q.size());
    end
    if (n_rd0 - b_rd0 != 2048) begin
      n_fail++; $display("FAIL alt_rd0: got %0d want 2048", n_rd0 - b_rd0);
    end
    if (n_rd1 - b_rd1 != 2048) begin
      n_fail++; $display("FAIL alt_rd1: got %0d want 2048", n_rd1 - b_rd1);
    end
    for (int k = 0; k < 4; k++) begin
      ch = rr_model(1, 1, m_last);
      m_last = ch;
      base = k * 1025;
      if (base >= wr_data_q.size()) break;
      n_checks += 3;
      if (wr_data_q[base] !== (8'hA0 | 8'(ch))) begin
        n_fail++; $display("FAIL alt_header%0d: got %h want %h", k, wr_data_q[base], 8'hA0 | 8'(ch));
      end
      if (wr_gnt_q[base] !== ((ch == 1) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL alt_grant%0d: got %b for ch%0d", k, wr_gnt_q[base], ch);
      end
      if (seq_errors(base + 1, ch, st[ch], 1024) != 0) begin
        n_fail++; $display("FAIL alt_data%0d: %0d bad bytes", k, seq_errors(base + 1, ch, st[ch], 1024));
      end
      st[ch] = st[ch] + 8'(1024);
      if (k > 0) begin
        gap = wr_cyc_q[base] - wr_cyc_q[base - 1] - 1;
        n_checks++;
        if (gap < 3) begin n_fail++; $display("FAIL alt_gap%0d: got %0d want >=3", k, gap); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] st;
    int ch;
    st = ptr1;
    mark();
    ch1_rdy = 1'b1;
    ch = rr_model(0, 1, m_last);
    m_last = ch;
    wait_done(1, 10000, 1, 0, "bp");
    ch1_rdy = 1'b0;
    repeat (5) tick();
    n_checks += 5;
    if (wr_data_q.size() != 1025) begin
      n_fail++; $display("FAIL bp_wr_count: got %0d want 1025", wr_data_q.size());
    end
    if (wr_data_q.size() > 0 && wr_data_q[0] !== (8'hA0 | 8'(ch))) begin
      n_fail++; $display("FAIL bp_header: got %h want %h", wr_data_q[0], 8'hA0 | 8'(ch));
    end
    if (seq_errors(1, ch, st, 1024) != 0) begin
      n_fail++; $display("FAIL bp_data: %0d bad bytes, want 0", seq_errors(1, ch, st, 1024));
    end
    if (n_rd1 - b_rd1 != 1024) begin
      n_fail++; $display("FAIL bp_rd1: got %0d want 1024", n_rd1 - b_rd1);
    end
    if (n_rd0 - b_rd0 != 0) begin
      n_fail++; $display("FAIL bp_rd0: got %0d want 0", n_rd0 - b_rd0);
    end
  endtask

  task automatic test_midburst_drop();
    logic [7:0] st0, st1;
    int first, second, badg, gap;
    st0 = ptr0;
    st1 = ptr1;
    mark();
    ch0_rdy = 1'b1;
    ch1_rdy = 1'b1;
    first = rr_model(1, 1, m_last);
    second = rr_model(0, 1, first);
    m_last = second;
    wait_done(2, 6000, 0, 300, "drop");
    ch1_rdy = 1'b0;
    repeat (5) tick();
    n_checks += 4;
    if (wr_data_q.size() != 2050) begin
      n_fail++; $display("FAIL drop_wr_count: got %0d want 2050", wr_data_q.size());
    end
    badg = 0;
    for (int i = 0; i < 1025 && i < wr_gnt_q.size(); i++)
      if (wr_gnt_q[i] !== ((first == 1) ? 2'b10 : 2'b01)) badg++;
    if (badg != 0) begin n_fail++; $display("FAIL drop_grant_hold: %0d cycles switched", badg); end
    if (seq_errors(1, first, (first == 1) ? st1 : st0, 1024) != 0) begin
      n_fail++; $display("FAIL drop_data: first burst has bad bytes");
    end
    if (n_rd0 - b_rd0 != 1024) begin
      n_fail++; $display("FAIL drop_rd0: got %0d want 1024", n_rd0 - b_rd0);
    end
    if (wr_data_q.size() > 1025) begin
      gap = wr_cyc_q[1025] - wr_cyc_q[1024] - 1;
      n_checks += 2;
      if (wr_data_q[1025] !== (8'hA0 | 8'(second))) begin
        n_fail++; $display("FAIL drop_second_header: got %h want %h", wr_data_q[1025],
                           8'hA0 | 8'(second));
      end
      if (gap < 3) begin n_fail++; $display("FAIL drop_gap: got %0d want >=3", gap); end
    end
  endtask

  task automatic test_reset_midburst();
    logic [7:0] st;
    int i, ch;
    mark();
    ch0_rdy = 1'b1;
    i = 0;
    while (wr_data_q.size() < 500 && i < 2000) begin tick(); i++; end
    n_checks++;
    if (wr_data_q.size() < 500) begin
      n_fail++; $display("FAIL rstmid_timeout: got %0d bytes want 500", wr_data_q.size());
    end
    rst = 1'b1;
    #1;
    n_checks += 5;
    if (wrreq !== 1'b0) begin n_fail++; $display("FAIL rstmid_wrreq: got %b want 0", wrreq); end
    if (rd0 !== 1'b0) begin n_fail++; $display("FAIL rstmid_rd0: got %b want 0", rd0); end
    if (grant !== 2'b00) begin n_fail++; $display("FAIL rstmid_grant: got %b want 00", grant); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    if (data !== 8'h00) begin n_fail++; $display("FAIL rstmid_data: got %h want 00", data); end
    tick();
    rst = 1'b0;
    ch0_rdy = 1'b0;
    ch1_rdy = 1'b1;
    m_last = 1;
    ch = rr_model(0, 1, m_last);
    m_last = ch;
    st = ptr1;
    mark();
    @(negedge clk);
    n_checks++;
    if (wrreq !== 1'b0 || rd0 !== 1'b0 || rdq1 !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_release: wr/rd0/rd1 got %b%b%b want 000", wrreq, rd0, rdq1);
    end
    wait_done(1, 3000, 0, 0, "rstmid");
    ch1_rdy = 1'b0;
    repeat (5) tick();
    n_checks += 3;
    if (wr_data_q.size() == 0 || wr_data_q[0] !== (8'hA0 | 8'(ch))) begin
      n_fail++; $display("FAIL rstmid_header: got %h want %h",
                         (wr_data_q.size() > 0) ? wr_data_q[0] : 8'h00, 8'hA0 | 8'(ch));
    end
    if (seq_errors(1, ch, st, 1024) != 0 || wr_data_q.size() != 1025) begin
      n_fail++; $display("FAIL rstmid_data: size %0d want 1025 with clean sequence",
                         wr_data_q.size());
    end
    if (n_rd1 - b_rd1 != 1024) begin
      n_fail++; $display("FAIL rstmid_rd1: got %0d want 1024", n_rd1 - b_rd1);
    end
  endtask

  task automatic test_small_build();
    logic [7:0] st;
    int i, bad, last;
    st = s_ptr1;
    mark();
    s_ch1_rdy = 1'b1;
    i = 0;
    while ((s_n_done - b_sdone) < 1 && i < 200) begin tick(); i++; end
    s_ch1_rdy = 1'b0;
    repeat (5) tick();
    n_checks += 6;
    if (s_wr_data_q.size() != 16) begin
      n_fail++; $display("FAIL small_wr_count: got %0d want 16", s_wr_data_q.size());
    end
    if (s_wr_data_q.size() == 0 || s_wr_data_q[0] !== fifo_byte(1, st, 0)) begin
      n_fail++; $display("FAIL small_first: got %h want %h",
                         (s_wr_data_q.size() > 0) ? s_wr_data_q[0] : 8'h00, fifo_byte(1, st, 0));
    end
    bad = 0;
    foreach (s_wr_data_q[k])
      if (s_wr_data_q[k] !== fifo_byte(1, st, k) || s_wr_gnt_q[k] !== 2'b10) bad++;
    if (bad != 0) begin n_fail++; $display("FAIL small_data: %0d bad bytes, want 0", bad); end
    if (s_n_rd1 - b_srd1 != 16 || s_n_rd0 - b_srd0 != 0) begin
      n_fail++; $display("FAIL small_rdreq: rd1 %0d rd0 %0d want 16 0", s_n_rd1 - b_srd1,
                         s_n_rd0 - b_srd0);
    end
    if (s_n_done - b_sdone != 1) begin
      n_fail++; $display("FAIL small_done_cnt: got %0d want 1", s_n_done - b_sdone);
    end
    last = (s_wr_cyc_q.size() > 0) ? s_wr_cyc_q[s_wr_cyc_q.size() - 1] : -10;
    if (s_done_cyc_q.size() == 0 || s_done_cyc_q[0] != last + 1) begin
      n_fail++; $display("FAIL small_done_time: got %0d want %0d",
                         (s_done_cyc_q.size() > 0) ? s_done_cyc_q[0] : -1, last + 1);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_channel();
    test_alternation();
    test_backpressure();
    test_midburst_drop();
    test_reset_midburst();
    test_small_build();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
